// File: rtl/jt89_cic_pkg.sv
// Shared width helpers, stage-mode type and output saturation for the jt89
// mixer / CIC interpolator.
package jt89_cic_pkg;

  typedef enum logic {STG_COMB, STG_INTEG} stage_mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Mixer sum width: enough headroom for NCH full-scale channels.
  function automatic int sw_w(input int cw, input int nch);
    return cw + clog2(nch);
  endfunction

  // Integrator width: CIC growth of R^ORDER plus a sign bit.
  function automatic int iw_w(input int cw, input int nch, input int order, input int rlog);
    return sw_w(cw, nch) + order * rlog + 1;
  endfunction

  // Zero-stuffed CIC has DC gain R^(ORDER-1); this shift removes it.
  function automatic int gsh_w(input int order, input int rlog);
    return (order - 1) * rlog;
  endfunction

  function automatic logic [31:0] sat_u(input logic signed [63:0] v, input int ow);
    logic signed [63:0] maxv;
    maxv = (64'sd1 <<< ow) - 64'sd1;
    if (v < 64'sd0)
      return '0;
    else if (v > maxv)
      return maxv[31:0];
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/jt89_cic_stage.sv
// One CIC cell: a comb (difference against the previous input) or an
// integrator (running sum), modular W-bit arithmetic, advancing on en.
module jt89_cic_stage
  import jt89_cic_pkg::*;
#(
  parameter int          W    = 16,
  parameter stage_mode_e MODE = STG_COMB
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (MODE == STG_COMB) begin : g_comb
    logic [W-1:0] dly;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout <= '0;
        dly  <= '0;
      end else if (en) begin
        dout <= din - dly;
        dly  <= din;
      end
    end
  end else begin : g_integ
    // Wrap-around is part of CIC operation; never saturate here.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        dout <= '0;
      else if (en)
        dout <= dout + din;
    end
  end

endmodule

// File: rtl/jt89_cic_mix.sv
// jt89 PSG channel mixer followed by an ORDER-stage CIC interpolator by 2^RLOG,
// gain-normalised and saturated to an OW-bit unsigned sample.
module jt89_cic_mix
  import jt89_cic_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CW    = 9,
  parameter int ORDER = 2,
  parameter int RLOG  = 4,
  parameter int OW    = 11
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [NCH*CW-1:0] chan,
  input  logic [NCH-1:0]    mute,
  output logic              cen_lo,
  output logic [OW-1:0]     sound,
  output logic              sound_vld
);

  localparam int SW  = sw_w(CW, NCH);
  localparam int IW  = iw_w(CW, NCH, ORDER, RLOG);
  localparam int GSH = gsh_w(ORDER, RLOG);

  if (NCH < 1 || NCH > 8 || CW < 1 || ORDER < 1 || ORDER > 4 ||
      RLOG < 1 || RLOG > 6 || OW < 1 || OW > 31 || IW > 63) begin : g_bad_param
    $error("jt89_cic_mix: illegal parameter set");
  end

  logic [RLOG-1:0]        phase;
  logic [SW-1:0]          mix, mix_d;
  logic [ORDER:0][IW-1:0] cchain, ichain;
  logic signed [IW-1:0]   lvl;

  assign cen_lo = cen & (&phase);

  always_comb begin
    mix_d = '0;
    for (int k = 0; k < NCH; k++)
      if (!mute[k]) mix_d = mix_d + SW'(chan[k*CW +: CW]);
  end

  // Channels and mute are only looked at on cen_lo, once per low-rate sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
      mix   <= '0;
    end else begin
      if (cen)    phase <= phase + RLOG'(1);
      if (cen_lo) mix   <= mix_d;
    end
  end

  assign cchain[0] = {{(IW-SW){1'b0}}, mix};
  // Zero-stuffing: the comb result enters only on the first tick after cen_lo.
  assign ichain[0] = (phase == '0) ? cchain[ORDER] : '0;

  for (genvar i = 0; i < ORDER; i++) begin : g_cic
    jt89_cic_stage #(.W(IW), .MODE(STG_COMB)) u_comb (
      .clk  (clk),
      .rst  (rst),
      .en   (cen_lo),
      .din  (cchain[i]),
      .dout (cchain[i+1])
    );
    jt89_cic_stage #(.W(IW), .MODE(STG_INTEG)) u_integ (
      .clk  (clk),
      .rst  (rst),
      .en   (cen),
      .din  (ichain[i]),
      .dout (ichain[i+1])
    );
  end

  assign lvl = $signed(ichain[ORDER]) >>> GSH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sound     <= '0;
      sound_vld <= 1'b0;
    end else begin
      sound_vld <= cen;
      if (cen) sound <= OW'(sat_u({{(64-IW){lvl[IW-1]}}, lvl}, OW));
    end
  end

endmodule

// File: tb/tb_jt89_cic_mix.sv
// Directed bench for jt89_cic_mix: reset, step/settling, saturation, mute
// timing, ramp-down, parameter sweep and sparse-cen equivalence.
module tb_jt89_cic_mix;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic [35:0] chan = '0;
  logic [3:0]  mute = '0;
  logic [8:0]  chan1 = 9'd37;
  logic        mute1 = 1'b0;

  logic        cen_lo, sound_vld;
  logic [10:0] sound;
  logic        o10_clo, o10_vld;
  logic [9:0]  o10_snd;
  logic [3:0]  s_clo, s_vld;
  logic [10:0] s_snd [4];

  always #5 clk = ~clk;

  jt89_cic_mix u_dut (
    .clk(clk), .rst(rst), .cen(cen), .chan(chan), .mute(mute),
    .cen_lo(cen_lo), .sound(sound), .sound_vld(sound_vld)
  );

  jt89_cic_mix #(.OW(10)) u_ow10 (
    .clk(clk), .rst(rst), .cen(cen), .chan(chan), .mute(mute),
    .cen_lo(o10_clo), .sound(o10_snd), .sound_vld(o10_vld)
  );

  jt89_cic_mix #(.NCH(1), .ORDER(1), .RLOG(1)) u_s0 (
    .clk(clk), .rst(rst), .cen(cen), .chan(chan1), .mute(mute1),
    .cen_lo(s_clo[0]), .sound(s_snd[0]), .sound_vld(s_vld[0])
  );
  jt89_cic_mix #(.NCH(1), .ORDER(1), .RLOG(6)) u_s1 (
    .clk(clk), .rst(rst), .cen(cen), .chan(chan1), .mute(mute1),
    .cen_lo(s_clo[1]), .sound(s_snd[1]), .sound_vld(s_vld[1])
  );
  jt89_cic_mix #(.NCH(1), .ORDER(3), .RLOG(1)) u_s2 (
    .clk(clk), .rst(rst), .cen(cen), .chan(chan1), .mute(mute1),
    .cen_lo(s_clo[2]), .sound(s_snd[2]), .sound_vld(s_vld[2])
  );
  jt89_cic_mix #(.NCH(1), .ORDER(3), .RLOG(6)) u_s3 (
    .clk(clk), .rst(rst), .cen(cen), .chan(chan1), .mute(mute1),
    .cen_lo(s_clo[3]), .sound(s_snd[3]), .sound_vld(s_vld[3])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mono(input int n, input bit up, output int viol);
    logic [10:0] prev;
    viol = 0;
    prev = sound;
    for (int i = 0; i < n; i++) begin
      tick();
      if (up ? (sound < prev) : (sound > prev)) viol++;
      prev = sound;
    end
  endtask

  logic [10:0] seq_a [80];
  logic [10:0] seq_b [80];

  initial begin
    int first, v, dev, na, nb, mm;
    int cl [5];

    repeat (2) tick();
    rst = 1'b1;
    cen = 1'b1;
    chan[8:0] = 9'd5;
    repeat (40) tick();

    // asynchronous reset in the middle of a cycle with live inputs
    rst = 1'b0;
    #1;
    chk("rst_sound", sound, 0);
    chk("rst_vld", sound_vld, 0);
    chk("rst_cen_lo", cen_lo, 0);
    tick();
    tick();
    chan[8:0] = 9'd100;
    rst = 1'b1;

    first = 0;
    for (int n = 1; n <= 40; n++) begin
      if (cen_lo) begin
        first = n;
        break;
      end
      tick();
    end
    chk("first_cen_lo", first, 16);

    run_mono(100, 1'b1, v);
    chk("step_mono", v, 0);
    chk("step_val", sound, 100);
    chk("ow10_step", o10_snd, 100);
    dev = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (sound !== 11'd100) dev++;
    end
    chk("step_hold", dev, 0);

    chan = {4{9'd511}};
    repeat (96) tick();
    chk("full_scale", sound, 2044);
    chk("ow10_sat", o10_snd, 1023);

    chan = {4{9'd200}};
    repeat (96) tick();
    chk("mute_pre", sound, 800);
    for (int i = 0; i < 16 && u_dut.phase != 4'd7; i++) tick();
    chk("mute_phase7", u_dut.phase, 7);
    mute = 4'b0101;
    repeat (3) tick();
    chk("mute_mix_hold", u_dut.mix, 800);
    repeat (6) tick();
    chk("mute_mix_new", u_dut.mix, 400);
    repeat (96) tick();
    chk("mute_val", sound, 400);

    mute = 4'b0000;
    chan = {4{9'd511}};
    repeat (96) tick();
    chan = '0;
    run_mono(120, 1'b0, v);
    chk("ramp_mono", v, 0);
    chk("ramp_zero", sound, 0);
    chk("ramp_integ_zero", u_dut.ichain, 0);

    // same step, cen every clk vs cen one clk in three
    chan[8:0] = 9'd100;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    na = 0;
    for (int c = 0; c < 200 && na < 80; c++) begin
      tick();
      if (sound_vld) begin
        seq_a[na] = sound;
        na++;
      end
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    nb = 0;
    for (int c = 0; c < 300 && nb < 80; c++) begin
      cen = (c % 3 == 0);
      tick();
      if (sound_vld) begin
        seq_b[nb] = sound;
        nb++;
      end
    end
    chk("div3_cnt", nb, 80);
    mm = 0;
    for (int i = 0; i < 80; i++)
      if (seq_a[i] !== seq_b[i]) mm++;
    chk("div3_seq", mm, 0);
    chk("div3_settled", seq_b[79], 100);

    cen = 1'b1;
    repeat (600) tick();
    chk("sweep_o1_r1", s_snd[0], 37);
    chk("sweep_o1_r6", s_snd[1], 37);
    chk("sweep_o3_r1", s_snd[2], 37);
    chk("sweep_o3_r6", s_snd[3], 37);
    chk("sweep_vld", {o10_vld, s_vld}, 5'h1f);

    for (int k = 0; k < 5; k++) cl[k] = 0;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++)
        if (s_clo[k]) cl[k]++;
      if (o10_clo) cl[4]++;
      tick();
    end
    chk("clo_r2_o1", cl[0], 32);
    chk("clo_r64_o1", cl[1], 1);
    chk("clo_r2_o3", cl[2], 32);
    chk("clo_r64_o3", cl[3], 1);
    chk("clo_r16", cl[4], 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
